// File: rtl/conv_window_streamer_if.sv
// Stream bundle for conv_window_streamer: raster pixel input and flattened window output.
// master = producer/consumer side, slave = streamer side.
interface conv_window_streamer_if #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned HEIGHT     = 3,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned PIX_W = DATA_WIDTH * DEPTH;
  localparam int unsigned WIN_W = PIX_W * WIDTH * HEIGHT;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [WIN_W-1:0] out_window;
  logic             out_last;

  modport master (
    output in_valid, in_pixel, in_sof, out_ready,
    input  in_ready, out_valid, out_window, out_last
  );

  modport slave (
    input  in_valid, in_pixel, in_sof, out_ready,
    output in_ready, out_valid, out_window, out_last
  );
endinterface

// File: rtl/conv_window_streamer.sv
// Raster pixel stream to flattened WIDTH x HEIGHT x DEPTH windows (valid conv, stride 1).
// Optional macro CONV_WIN_SOF_RESYNC_EN: an accepted pixel with in_sof restarts the frame at (0,0).
module conv_window_streamer #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned HEIGHT     = 3,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32
) (
  input logic                    clk,
  input logic                    rst,
  conv_window_streamer_if.slave  io_s
);
  localparam int unsigned PIX_W = DATA_WIDTH * DEPTH;
  localparam int unsigned WIN_W = PIX_W * WIDTH * HEIGHT;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

`ifdef CONV_WIN_SOF_RESYNC_EN
  localparam bit SOF_RESYNC = 1'b1;
`else
  localparam bit SOF_RESYNC = 1'b0;
`endif

  logic [COL_W-1:0] r_col, w_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row, w_row_nxt;
  logic             w_accept, w_sof, w_last_col, w_last_row, w_emit, w_last;

  logic [PIX_W-1:0] r_lb     [HEIGHT-1][IMG_W];
  logic [PIX_W-1:0] r_win    [WIDTH][HEIGHT];
  logic [PIX_W-1:0] w_new    [WIDTH][HEIGHT];
  logic [PIX_W-1:0] w_column [HEIGHT];
  logic [WIN_W-1:0] w_flat;

  logic             r_out_valid;
  logic             r_out_last;
  logic [WIN_W-1:0] r_out_window;

  assign io_s.in_ready   = !r_out_valid || io_s.out_ready;
  assign io_s.out_valid  = r_out_valid;
  assign io_s.out_last   = r_out_last;
  assign io_s.out_window = r_out_window;

  assign w_accept = io_s.in_valid && io_s.in_ready;
  assign w_sof    = io_s.in_sof && SOF_RESYNC;

  // Position of the pixel being offered; a resync pixel is treated as (0,0).
  always_comb begin
    w_col = r_col;
    w_row = r_row;
    if (w_sof) begin
      w_col = '0;
      w_row = '0;
    end
  end

  assign w_last_col = (w_col == COL_W'(IMG_W - 1));
  assign w_last_row = (w_row == ROW_W'(IMG_H - 1));
  assign w_col_nxt  = w_last_col ? '0 : w_col + COL_W'(1);
  assign w_row_nxt  = w_last_col ? (w_last_row ? '0 : w_row + ROW_W'(1)) : w_row;
  assign w_last     = w_last_col && w_last_row;
  assign w_emit     = w_accept && (w_col >= COL_W'(WIDTH - 1)) && (w_row >= ROW_W'(HEIGHT - 1));

  // New rightmost column (oldest row at j=0), shifted window, and flattened patch.
  always_comb begin
    w_column[HEIGHT-1] = io_s.in_pixel;
    for (int h = 0; h < HEIGHT - 1; h++) begin
      w_column[HEIGHT-2-h] = r_lb[h][w_col];
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      for (int j = 0; j < HEIGHT; j++) begin
        w_new[i][j] = r_win[i+1][j];
      end
    end
    for (int j = 0; j < HEIGHT; j++) begin
      w_new[WIDTH-1][j] = w_column[j];
    end
    w_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < HEIGHT; j++) begin
        for (int i = 0; i < WIDTH; i++) begin
          w_flat[(k*WIDTH*HEIGHT + j*WIDTH + i)*DATA_WIDTH +: DATA_WIDTH] =
            w_new[i][j][k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Line buffers and shift array carry no reset; the counters keep stale data out of windows.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][w_col] <= io_s.in_pixel;
      for (int h = 1; h < HEIGHT - 1; h++) begin
        r_lb[h][w_col] <= r_lb[h-1][w_col];
      end
      r_win <= w_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_window <= '0;
    end else begin
      if (w_accept) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
      end
      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_last   <= w_last;
        r_out_window <= w_flat;
      end else if (io_s.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end
endmodule
